// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the register file geometry, the queued write-request record and the
// producer identifiers used by the round-robin arbiter.
package regfile_wb_arbiter_pkg;

    localparam int DEPTH      = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    // One write-back request: destination register plus result.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Producer identity; also the encoding of the round-robin pointer.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_RX  = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   push, push_req    enqueue one request (caller guarantees not full)
//   pop, head         dequeue; head is the oldest entry (caller guarantees not empty)
//   count/full/empty  occupancy status
//   entry_valid/addr  per-slot view of occupied entries for hazard decode
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  wb_req_t                               push_req,
    input  logic                                  pop,
    output wb_req_t                               head,
    output logic [CNT_W-1:0]                      count,
    output logic                                  full,
    output logic                                  empty,
    output logic [FIFO_DEPTH-1:0]                 entry_valid,
    output logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr
);

    wb_req_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] offset;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is not reset; occupancy is defined solely by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Slot i is occupied when its distance from the read pointer is below count.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
        offset      = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back front end of the 32x64 register file.
// Round-robin arbitrates ALU (src0) and load/NoC receive (src1) results,
// queues accepted writes, drives the single register-file write port from a
// registered output stage, and exports a per-register pending-write vector.
// Optional build macro: WB_DROP_R0_EN -- writes to register 0 are accepted
// but discarded, and pending[0] is tied low.
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-low reset
//   s0_valid/ready/addr/data      ALU write request channel
//   s1_valid/ready/addr/data      load/NoC receive write request channel
//   wr_stall                      write port borrowed; no pop this cycle
//   wb_wrEn/wb_wrAddr/wb_data     registered register-file write port
//   pending                       bit r set while a write to r is outstanding
//   fifo_count                    current queue occupancy
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s0_valid,
    output logic                          s0_ready,
    input  logic [ADDR_WIDTH-1:0]         s0_addr,
    input  logic [DATA_WIDTH-1:0]         s0_data,
    input  logic                          s1_valid,
    output logic                          s1_ready,
    input  logic [ADDR_WIDTH-1:0]         s1_addr,
    input  logic [DATA_WIDTH-1:0]         s1_data,
    input  logic                          wr_stall,
    output logic                          wb_wrEn,
    output logic [ADDR_WIDTH-1:0]         wb_wrAddr,
    output logic [DATA_WIDTH-1:0]         wb_data,
    output logic [DEPTH-1:0]              pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    src_e                                  rr;
    logic                                  grant0;
    logic                                  grant1;
    logic                                  accept0;
    logic                                  accept1;
    logic                                  push;
    logic                                  pop;
    logic                                  full;
    logic                                  empty;
    wb_req_t                               push_req;
    wb_req_t                               head;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;

    // A lone requester always wins; on a contest the source that did not
    // win last time (the one other than rr) is granted.
    assign grant0   = s0_valid && (!s1_valid || rr == SRC_RX);
    assign grant1   = s1_valid && (!s0_valid || rr == SRC_ALU);

    // Full blocks both sources even if a pop frees a slot this same cycle.
    assign s0_ready = grant0 && !full;
    assign s1_ready = grant1 && !full;
    assign accept0  = s0_valid && s0_ready;
    assign accept1  = s1_valid && s1_ready;

    always_comb begin
        push_req.addr = accept1 ? s1_addr : s0_addr;
        push_req.data = accept1 ? s1_data : s0_data;
    end

`ifdef WB_DROP_R0_EN
    // R0 writes complete the handshake but never enter the queue.
    assign push = (accept0 || accept1) && (push_req.addr != '0);
`else
    assign push = accept0 || accept1;
`endif

    assign pop = !empty && !wr_stall;

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_req    (push_req),
        .pop         (pop),
        .head        (head),
        .count       (fifo_count),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // rr records the last source whose write was queued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr <= SRC_RX;
        end else if (push) begin
            rr <= accept1 ? SRC_RX : SRC_ALU;
        end
    end

    // Output stage: address/data hold their last values when nothing pops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_wrEn   <= 1'b0;
            wb_wrAddr <= '0;
            wb_data   <= '0;
        end else begin
            wb_wrEn <= pop;
            if (pop) begin
                wb_wrAddr <= head.addr;
                wb_data   <= head.data;
            end
        end
    end

    // A register stays pending until its last write has left the output stage.
    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) pending[entry_addr[i]] = 1'b1;
        end
        if (wb_wrEn) pending[wb_wrAddr] = 1'b1;
`ifdef WB_DROP_R0_EN
        pending[0] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model, with a
// scoreboard that matches every register-file write in acceptance order.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int FD = 4;
`ifdef WB_DROP_R0_EN
    localparam bit DROP_R0 = 1'b1;
`else
    localparam bit DROP_R0 = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  s0_valid = 1'b0;
    logic                  s0_ready;
    logic [ADDR_WIDTH-1:0] s0_addr = '0;
    logic [DATA_WIDTH-1:0] s0_data = '0;
    logic                  s1_valid = 1'b0;
    logic                  s1_ready;
    logic [ADDR_WIDTH-1:0] s1_addr = '0;
    logic [DATA_WIDTH-1:0] s1_data = '0;
    logic                  wr_stall = 1'b0;
    logic                  wb_wrEn;
    logic [ADDR_WIDTH-1:0] wb_wrAddr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DEPTH-1:0]      pending;
    logic [$clog2(FD):0]   fifo_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_addr    (s0_addr),
        .s0_data    (s0_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_addr    (s1_addr),
        .s1_data    (s1_data),
        .wr_stall   (wr_stall),
        .wb_wrEn    (wb_wrEn),
        .wb_wrAddr  (wb_wrAddr),
        .wb_data    (wb_data),
        .pending    (pending),
        .fifo_count (fifo_count)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: pending source requests, queued writes, the write in
    // the output stage, the last winning source, and the scoreboard.
    wb_req_t src_q0[$];
    wb_req_t src_q1[$];
    wb_req_t model_q[$];
    wb_req_t sb_q[$];
    wb_req_t out_item;
    bit      out_valid = 1'b0;
    int      last_src  = 1;
    int      win       = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DEPTH-1:0] model_pending();
        logic [DEPTH-1:0] p;
        p = '0;
        foreach (model_q[i]) p[model_q[i].addr] = 1'b1;
        if (out_valid) p[out_item.addr] = 1'b1;
        return p;
    endfunction

    function automatic wb_req_t mk(input int addr, input logic [63:0] data);
        wb_req_t r;
        r.addr = ADDR_WIDTH'(addr);
        r.data = data;
        return r;
    endfunction

    // One clock cycle: entered and left at posedge+1.
    task automatic cycle(input bit stall, input int pct);
        bit      full;
        wb_req_t item;
        wr_stall = stall;
        s0_valid = (src_q0.size() > 0) && ($urandom_range(99) < pct);
        s1_valid = (src_q1.size() > 0) && ($urandom_range(99) < pct);
        if (src_q0.size() > 0) begin s0_addr = src_q0[0].addr; s0_data = src_q0[0].data; end
        if (src_q1.size() > 0) begin s1_addr = src_q1[0].addr; s1_data = src_q1[0].data; end
        @(negedge clk);
        if (s0_valid && s1_valid) win = (last_src == 0) ? 1 : 0;
        else if (s0_valid)        win = 0;
        else if (s1_valid)        win = 1;
        else                      win = -1;
        full = (model_q.size() >= FD);
        check("fifo_count", 64'(fifo_count), 64'(model_q.size()));
        check("s0_ready", 64'(s0_ready), 64'(win == 0 && !full));
        check("s1_ready", 64'(s1_ready), 64'(win == 1 && !full));
        check("wb_wrEn", 64'(wb_wrEn), 64'(out_valid));
        check("pending", 64'(pending), 64'(model_pending()));
        @(posedge clk);
        if (model_q.size() > 0 && !stall) begin
            out_item  = model_q.pop_front();
            out_valid = 1'b1;
        end else begin
            out_valid = 1'b0;
        end
        if (win >= 0 && !full) begin
            item = (win == 0) ? src_q0.pop_front() : src_q1.pop_front();
            if (!(DROP_R0 && item.addr == 0)) begin
                model_q.push_back(item);
                sb_q.push_back(item);
                last_src = win;
            end
        end
        #1;
    endtask

    task automatic run(input int n, input bit stall);
        for (int i = 0; i < n; i++) cycle(stall, 100);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles &&
             (src_q0.size() > 0 || src_q1.size() > 0 || model_q.size() > 0 || out_valid); i++)
            cycle(1'b0, 100);
        check("drain_scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // One-cycle synchronous reset, then the reset state is checked.
    task automatic do_reset();
        reset    = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        wr_stall = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        src_q0.delete();
        src_q1.delete();
        model_q.delete();
        sb_q.delete();
        out_valid = 1'b0;
        last_src  = 1;
        @(negedge clk);
        check("rst_wb_wrEn", 64'(wb_wrEn), 64'd0);
        check("rst_wb_wrAddr", 64'(wb_wrAddr), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every register-file write must match the oldest
    // outstanding accepted write.
    initial begin
        wb_req_t exp;
        forever begin
            @(negedge clk);
            if (wb_wrEn === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks_total++;
                    $display("FAIL wb_unexpected: got write to r%0d, expected none", wb_wrAddr);
                end else begin
                    exp = sb_q.pop_front();
                    check("wb_wrAddr", 64'(wb_wrAddr), 64'(exp.addr));
                    check("wb_data", wb_data, exp.data);
                end
            end
        end
    end

    initial begin
        do_reset();

        // Single ALU write to r5.
        src_q0.push_back(mk(5, 64'hDEAD_BEEF_0000_0001));
        run(5, 1'b0);
        drain(10);

        // Both sources contending: alternation s0,s1,s0,s1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_q0.push_back(mk(1 + i, {$urandom, $urandom}));
            src_q1.push_back(mk(17 + i, {$urandom, $urandom}));
        end
        run(8, 1'b0);
        drain(20);

        // Stalled write port fills the queue, then releases in order.
        for (int i = 0; i < 6; i++) begin
            src_q0.push_back(mk($urandom_range(31), {$urandom, $urandom}));
            src_q1.push_back(mk($urandom_range(31), {$urandom, $urandom}));
        end
        run(8, 1'b1);
        check("stall_fifo_full", 64'(fifo_count), 64'd4);
        drain(40);

        // Two writes to r9: pending held until the later one leaves.
        src_q0.push_back(mk(9, 64'hAAAA_0000_0000_000A));
        src_q0.push_back(mk(9, 64'hBBBB_0000_0000_000B));
        drain(20);

        // Reset with three queued writes and one in the output stage.
        for (int i = 0; i < 4; i++) src_q0.push_back(mk(10 + i, {$urandom, $urandom}));
        run(4, 1'b1);
        run(1, 1'b0);
        check("pre_reset_wb_wrEn", 64'(wb_wrEn), 64'd1);
        check("pre_reset_fifo_count", 64'(fifo_count), 64'd3);
        do_reset();
        run(6, 1'b0);

        // R0 write.
        src_q0.push_back(mk(0, 64'h1234));
        run(4, 1'b0);
        drain(10);

        // Randomized traffic with random stalls and request gaps.
        for (int i = 0; i < 150; i++) begin
            src_q0.push_back(mk($urandom_range(31), {$urandom, $urandom}));
            src_q1.push_back(mk($urandom_range(31), {$urandom, $urandom}));
        end
        for (int i = 0; i < 400; i++) cycle($urandom_range(99) < 25, 70);
        drain(400);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
